mc6800_bus_sequencer: RTL and testbench
=======================================

Name: mc6800_bus_sequencer

Overview:
Bus-cycle controller for the accelerator-to-motherboard interface. It classifies each CPU bus cycle as one of four kinds: asynchronous (motherboard DTACK), synchronous 6800 (VPA), autovector interrupt acknowledge, or timed-out (bus error). It then sequences the matching handshake against the E-clock phase counter supplied by the E-clock generator. It sits between the CPU-side strobes and the motherboard strobes and is the single owner of VMA, CPU DTACK, AVEC and BERR.

Parameters:
E_PERIOD, 10, CLK cycles per E-clock period; E_PHASE counts 0..E_PERIOD-1.
VMA_PHASE, 2, E_PHASE value at which VMA may assert.
DTACK_PHASE, 8, E_PHASE value at which a 6800-cycle DTACK asserts.
TIMEOUT_CYCLES, 256, synchronised CLK cycles in WAIT_ACK before BERR asserts.

Ports:
CLK  input  1  motherboard 7 MHz clock; all state updates on its rising edge.
RESET  input  1  asynchronous, active-low reset.
AS  input  1  CPU address strobe, active-low.
FC  input  3  CPU function code; 3'b111 = CPU space.
VPA  input  1  motherboard valid peripheral address, active-low.
MB_DTACK  input  1  motherboard DTACK, active-low.
E_PHASE  input  4  E-clock ring-counter value from the E-clock generator.
VMA  output  1  valid memory address to 6800 peripherals, active-low.
DTACK  output  1  DTACK to the CPU, active-low.
AVEC  output  1  autovector request to the CPU, active-low.
BERR  output  1  bus error to the CPU, active-low.

Behaviour:
- Reset (RESET low, asynchronous): state IDLE; VMA, DTACK, AVEC and BERR all 1; timeout counter 0; synchronisers preset to 1.
- AS, VPA and MB_DTACK each pass through a 2-flop synchroniser. "Seen" means the synchronised value. FC is sampled when the synchronised AS falls.
- IDLE: on AS seen low, go to WAIT_ACK and clear the timeout counter.
- WAIT_ACK: check in this priority order each cycle:
  1. MB_DTACK low -> ASYNC_ACK.
  2. Else VPA low and FC == 3'b111 -> AUTOVEC.
  3. Else VPA low -> SYNC_E.
  4. Else, if the counter == TIMEOUT_CYCLES-1 -> BUSERR.
  5. Else increment the counter (saturating width = clog2(TIMEOUT_CYCLES)).
- ASYNC_ACK: DTACK = 0.
- AUTOVEC: AVEC = 0. VMA never asserts.
- BUSERR: BERR = 0.
- SYNC_E: wait for E_PHASE == VMA_PHASE, then go to VMA_ACT with VMA = 0 from the next edge. If VPA is first seen while E_PHASE > VMA_PHASE, wait for the next period. There is no timeout in SYNC_E or VMA_ACT; the worst case is 2*E_PERIOD cycles.
- VMA_ACT: at E_PHASE == DTACK_PHASE, DTACK = 0 (go to SYNC_ACK). In SYNC_ACK, at E_PHASE == E_PERIOD-1, VMA and DTACK return to 1, then go to TERM.
- TERM: all outputs 1; go to IDLE when AS is seen high. This prevents a single long AS from producing two acknowledges.
- ASYNC_ACK, AUTOVEC and BUSERR hold their strobe low until AS is seen high. Then the strobe returns to 1 on that same edge and the state goes to IDLE.
- AS seen high in any non-IDLE state: all outputs return to 1 on that edge and the state goes to IDLE (aborted cycle). VMA never remains low after AS negates.
- Outputs are registered and glitch-free. At most one of DTACK, AVEC and BERR is low at any time.
- Reset asserted mid-cycle: outputs go high immediately (asynchronously), regardless of E_PHASE.
- E_PHASE values >= E_PERIOD are treated as never matching.

Decomposition:
- Shared package mc6800_pkg: state enum (IDLE, WAIT_ACK, ASYNC_ACK, AUTOVEC, BUSERR, SYNC_E, VMA_ACT, SYNC_ACK, TERM), FC_CPU_SPACE = 3'b111, and the default phase constants.
- One sub-module, sync2_preset: a 2-flop synchroniser that presets to 1 on asynchronous reset, instantiated three times.

Test Plan:
1. Async cycle: AS low, MB_DTACK low 5 cycles later -> DTACK low 2-3 cycles after MB_DTACK falls; DTACK high on the edge after AS is seen high; VMA stays 1.
2. 6800 cycle: AS low, VPA low with E_PHASE=5 -> VMA low after E_PHASE=2 of the next period; DTACK low after E_PHASE=8; both high after E_PHASE=9; state reaches TERM, then IDLE on AS high.
3. Autovector: FC=3'b111, VPA low -> AVEC low; VMA never asserts; AVEC high after AS negates.
4. Timeout: AS low with no VPA and no MB_DTACK -> BERR low exactly TIMEOUT_CYCLES cycles after WAIT_ACK entry; cleared after AS high. Repeat with TIMEOUT_CYCLES=16.
5. Priority: MB_DTACK and VPA fall on the same edge -> DTACK via ASYNC_ACK; VMA stays 1.
6. Abort/reset: AS high while in VMA_ACT -> VMA high on the next edge, state IDLE. RESET low while in SYNC_ACK -> all outputs 1 asynchronously; first cycle after reset release behaves as in scenario 2.

Source files
------------

// File: rtl/mc6800_pkg.sv
// Shared types and defaults for the 68000-to-motherboard bus sequencer.
// Holds the sequencer state enum, CPU-space function code and phase defaults.
package mc6800_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WAIT_ACK,
    ASYNC_ACK,
    AUTOVEC,
    BUSERR,
    SYNC_E,
    VMA_ACT,
    SYNC_ACK,
    TERM
  } state_t;

  localparam logic [2:0] FC_CPU_SPACE = 3'b111;

  localparam int E_PERIOD_DEF    = 10;
  localparam int VMA_PHASE_DEF   = 2;
  localparam int DTACK_PHASE_DEF = 8;
  localparam int TIMEOUT_DEF     = 256;

endpackage

// File: rtl/mc6800_bus_sequencer_sync2_preset.sv
// Two-flop synchroniser that presets to 1 on asynchronous reset.
// Ports: i_clk, i_rst_n (active-low async), i_d (async input), o_q (synchronised).
module sync2_preset (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_ff;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_ff <= 2'b11;
    else          r_ff <= {r_ff[0], i_d};
  end

  assign o_q = r_ff[1];

endmodule

// File: rtl/mc6800_bus_sequencer.sv
// Bus-cycle sequencer: classifies each CPU cycle (DTACK, 6800/VPA, autovector,
// timeout) and drives VMA, DTACK, AVEC, BERR (all active-low, registered).
// Inputs: CLK, RESET (async active-low), AS, FC[2:0], VPA, MB_DTACK, E_PHASE[3:0].
module mc6800_bus_sequencer
  import mc6800_pkg::*;
#(
  parameter int E_PERIOD       = E_PERIOD_DEF,
  parameter int VMA_PHASE      = VMA_PHASE_DEF,
  parameter int DTACK_PHASE    = DTACK_PHASE_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       AS,
  input  logic [2:0] FC,
  input  logic       VPA,
  input  logic       MB_DTACK,
  input  logic [3:0] E_PHASE,
  output logic       VMA,
  output logic       DTACK,
  output logic       AVEC,
  output logic       BERR
);

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] VMA_PH = 4'(VMA_PHASE);
  localparam logic [3:0] DTK_PH = 4'(DTACK_PHASE);
  localparam logic [3:0] END_PH = 4'(E_PERIOD - 1);

  state_t        r_state, w_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_fc;
  logic          r_vma, r_dtk, r_avec, r_berr;
  logic          w_as_s, w_vpa_s, w_dtk_s;
  logic          w_ph_ok;
  logic          w_vma_hit, w_dtk_hit, w_end_hit;

  sync2_preset u_as (
    .i_clk(CLK), .i_rst_n(RESET), .i_d(AS), .o_q(w_as_s)
  );
  sync2_preset u_vpa (
    .i_clk(CLK), .i_rst_n(RESET), .i_d(VPA), .o_q(w_vpa_s)
  );
  sync2_preset u_dtk (
    .i_clk(CLK), .i_rst_n(RESET), .i_d(MB_DTACK), .o_q(w_dtk_s)
  );

  // Out-of-range phase codes must never match a phase event.
  assign w_ph_ok   = {28'd0, E_PHASE} < 32'(E_PERIOD);
  assign w_vma_hit = w_ph_ok && (E_PHASE == VMA_PH);
  assign w_dtk_hit = w_ph_ok && (E_PHASE == DTK_PH);
  assign w_end_hit = w_ph_ok && (E_PHASE == END_PH);

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    // AS negation ends any cycle, wherever the handshake has got to.
    if (r_state != IDLE && w_as_s) begin
      w_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (!w_as_s) begin
            w_nxt     = WAIT_ACK;
            w_cnt_nxt = '0;
          end
        end
        WAIT_ACK: begin
          if (!w_dtk_s)
            w_nxt = ASYNC_ACK;
          else if (!w_vpa_s && r_fc == FC_CPU_SPACE)
            w_nxt = AUTOVEC;
          else if (!w_vpa_s)
            w_nxt = SYNC_E;
          else if (r_cnt == CNT_LAST)
            w_nxt = BUSERR;
          else if (r_cnt != '1)
            w_cnt_nxt = r_cnt + 1'b1;
        end
        SYNC_E:   if (w_vma_hit) w_nxt = VMA_ACT;
        VMA_ACT:  if (w_dtk_hit) w_nxt = SYNC_ACK;
        SYNC_ACK: if (w_end_hit) w_nxt = TERM;
        default:  w_nxt = r_state;
      endcase
    end
  end

  // Strobes are decoded from the next state into flops so they never glitch.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_fc    <= '0;
      r_vma   <= 1'b1;
      r_dtk   <= 1'b1;
      r_avec  <= 1'b1;
      r_berr  <= 1'b1;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state == IDLE && !w_as_s) r_fc <= FC;
      r_vma  <= !(w_nxt == VMA_ACT || w_nxt == SYNC_ACK);
      r_dtk  <= !(w_nxt == ASYNC_ACK || w_nxt == SYNC_ACK);
      r_avec <= (w_nxt != AUTOVEC);
      r_berr <= (w_nxt != BUSERR);
    end
  end

  assign VMA   = r_vma;
  assign DTACK = r_dtk;
  assign AVEC  = r_avec;
  assign BERR  = r_berr;

endmodule

// File: tb/tb_mc6800_bus_sequencer.sv
// Randomised transaction bench for mc6800_bus_sequencer.
// Two instances share stimulus: default timeout and a 16-cycle timeout.
module tb_mc6800_bus_sequencer;

  localparam int TA = 256;
  localparam int TB = 16;
  localparam int N  = 512;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       AS, VPA, MB_DTACK;
  logic [2:0] FC;
  logic [3:0] E_PHASE;
  logic       vma_a, dtk_a, avec_a, berr_a;
  logic       vma_b, dtk_b, avec_b, berr_b;

  int n_vec = 0;
  int n_err = 0;

  int         h, d, v, gap, len, ring, md, f_a;
  bit         use_d, use_v, dr;
  logic [2:0] fc;
  int         phs [N];
  logic [3:0] expa [N];
  logic [3:0] expb [N];

  mc6800_bus_sequencer u_dut_a (
    .CLK(CLK), .RESET(RESET), .AS(AS), .FC(FC), .VPA(VPA),
    .MB_DTACK(MB_DTACK), .E_PHASE(E_PHASE),
    .VMA(vma_a), .DTACK(dtk_a), .AVEC(avec_a), .BERR(berr_a)
  );

  mc6800_bus_sequencer #(.TIMEOUT_CYCLES(TB)) u_dut_b (
    .CLK(CLK), .RESET(RESET), .AS(AS), .FC(FC), .VPA(VPA),
    .MB_DTACK(MB_DTACK), .E_PHASE(E_PHASE),
    .VMA(vma_b), .DTACK(dtk_b), .AVEC(avec_b), .BERR(berr_b)
  );

  always #5 CLK = ~CLK;

  initial begin
    #3ms;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [3:0] got,
                       input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int first_at(input int from, input int val);
    for (int x = from + 1; x < N; x++)
      if (phs[x] == val) return x;
    return N + 8;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Strobe bits: [3]=VMA [2]=DTACK [1]=AVEC [0]=BERR, driven low in [lo,hi).
  task automatic clr(input bit sel, input int b, input int lo, input int hi);
    for (int x = lo; x < hi && x < len; x++)
      if (sel) expb[x][b] = 1'b0;
      else     expa[x][b] = 1'b0;
  endtask

  // Edge x is the x-th rising edge after AS is first driven low. Inputs are
  // seen by the FSM two edges after capture, so the cycle opens at edge 2,
  // responses act from edge 3, and AS negation is acted on at edge h+2.
  task automatic model(input int t, input bit sel);
    int hh, xd, xv, ar, e1, f1, g1;
    hh = h + 2;
    for (int x = 0; x < N; x++)
      if (sel) expb[x] = 4'hF;
      else     expa[x] = 4'hF;
    xd = use_d ? ((d + 2 > 3) ? d + 2 : 3) : (1 << 20);
    xv = use_v ? ((v + 2 > 3) ? v + 2 : 3) : (1 << 20);
    ar = imin(xd, xv);
    if (ar <= 2 + t) begin
      if (xd == ar) begin
        clr(sel, 2, ar, hh);
      end else if (fc == 3'b111) begin
        clr(sel, 1, ar, hh);
      end else begin
        e1 = first_at(ar, 2);
        f1 = first_at(e1, 8);
        g1 = first_at(f1, 9);
        clr(sel, 3, e1, imin(g1, hh));
        clr(sel, 2, f1, imin(g1, hh));
        if (!sel) f_a = f1;
      end
    end else begin
      clr(sel, 0, 2 + t, hh);
    end
  endtask

  task automatic run_txn(input bit do_rst, output bit did_rst);
    int rst_at;
    if (use_d && d >= h) use_d = 1'b0;
    if (use_v && v >= h) use_v = 1'b0;
    len = h + 2 + gap;
    ring = ring % md;
    for (int x = 0; x < N; x++) phs[x] = (ring + x) % md;
    f_a = -1;
    model(TA, 1'b0);
    model(TB, 1'b1);
    rst_at = do_rst ? f_a : -1;
    did_rst = 1'b0;
    for (int x = 0; x < len; x++) begin
      @(negedge CLK);
      AS       = (x < h) ? 1'b0 : 1'b1;
      MB_DTACK = (use_d && x >= d && x < h) ? 1'b0 : 1'b1;
      VPA      = (use_v && x >= v && x < h) ? 1'b0 : 1'b1;
      FC       = fc;
      E_PHASE  = 4'(phs[x]);
      @(posedge CLK);
      #1;
      check("dutA", {vma_a, dtk_a, avec_a, berr_a}, expa[x]);
      check("dutB", {vma_b, dtk_b, avec_b, berr_b}, expb[x]);
      if (x == rst_at) begin
        #1 RESET = 1'b0;
        #1;
        check("rstA", {vma_a, dtk_a, avec_a, berr_a}, 4'hF);
        check("rstB", {vma_b, dtk_b, avec_b, berr_b}, 4'hF);
        did_rst = 1'b1;
        break;
      end
    end
    ring = (ring + len) % md;
  endtask

  // kind: 0 async, 1 6800, 2 autovector, 3 timeout, 4 DTACK+VPA together
  task automatic setup(input int kind);
    use_d = 1'b0;
    use_v = 1'b0;
    d     = $urandom_range(0, 12);
    v     = $urandom_range(0, 12);
    fc    = 3'($urandom_range(0, 6));
    h     = $urandom_range(1, 80);
    gap   = $urandom_range(1, 4);
    md    = ($urandom_range(0, 3) == 0) ? 12 : 10;
    case (kind)
      0: use_d = 1'b1;
      1: use_v = 1'b1;
      2: begin use_v = 1'b1; fc = 3'b111; end
      3: h = $urandom_range(230, 300);
      default: begin
        use_d = 1'b1;
        use_v = 1'b1;
        v     = d;
        fc    = 3'($urandom_range(0, 7));
      end
    endcase
  endtask

  initial begin
    RESET    = 1'b0;
    AS       = 1'b1;
    VPA      = 1'b1;
    MB_DTACK = 1'b1;
    FC       = 3'd0;
    E_PHASE  = 4'd0;
    ring     = 0;
    md       = 10;
    repeat (3) @(negedge CLK);
    check("resetA", {vma_a, dtk_a, avec_a, berr_a}, 4'hF);
    check("resetB", {vma_b, dtk_b, avec_b, berr_b}, 4'hF);
    RESET = 1'b1;

    for (int i = 0; i < 5; i++) begin
      setup(i);
      h = (i == 3) ? 280 : 70;
      run_txn(1'b0, dr);
    end
    for (int i = 0; i < 140; i++) begin
      setup($urandom_range(0, 4));
      run_txn(1'b0, dr);
    end

    use_d = 1'b0;
    use_v = 1'b1;
    v     = 0;
    fc    = 3'd2;
    h     = 200;
    gap   = 2;
    md    = 10;
    run_txn(1'b1, dr);
    check("rst_hit", {3'b000, dr}, 4'h1);
    @(negedge CLK);
    AS       = 1'b1;
    VPA      = 1'b1;
    MB_DTACK = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst_hold", {vma_a, dtk_a, avec_a, berr_a}, 4'hF);
    RESET = 1'b1;

    setup(1);
    v = 3;
    h = 70;
    run_txn(1'b0, dr);
    for (int i = 0; i < 20; i++) begin
      setup($urandom_range(0, 4));
      run_txn(1'b0, dr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
